// File: rtl/sync_frame_pkg.sv
// Types and default sync framing shared by the serial frame transmitter and its matching receiver.
package sync_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SYNC   = 2'b01,
        DATA   = 2'b10,
        PARITY = 2'b11
    } statetype;

    localparam int                      SYNC_LEN_DEF     = 4;
    localparam logic [SYNC_LEN_DEF-1:0] SYNC_PATTERN_DEF = 4'b1101;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB out first, zero-fill; load wins over shift.
// One-cycle load latency; no flow control, the owner decides when to shift.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame tx: sync pattern, data MSB-first, optional even parity (SYNC_FRAME_TX_PARITY_EN).
// First bit one cycle after accept; ready only in IDLE, valid while busy is ignored (no queuing).
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int                  WIDTH        = 8,
    parameter int                  SYNC_LEN     = SYNC_LEN_DEF,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             sof,
    output logic             done
);

    localparam int MAX_LEN = (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PAD_W   = 1 << CNT_W;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
    // Padded so the counter can index it at full width.
    localparam logic [PAD_W-1:0] SYNC_PAD  = PAD_W'(SYNC_PATTERN);

    statetype         state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, cnt_nxt;
    logic             load, shift, shreg_msb;

    piso_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .d     (data_in),
        .msb   (shreg_msb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

`ifdef SYNC_FRAME_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^data_in;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (valid && ready) begin
                    state_nxt = SYNC;
                    cnt_nxt   = SYNC_LAST;
                    load      = 1'b1;
                end
            end
            SYNC: begin
                if (bit_cnt == '0) begin
                    state_nxt = DATA;
                    cnt_nxt   = DATA_LAST;
                end else begin
                    cnt_nxt = bit_cnt - CNT_W'(1);
                end
            end
            DATA: begin
                shift = 1'b1;
                if (bit_cnt == '0) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
`endif
                end else begin
                    cnt_nxt = bit_cnt - CNT_W'(1);
                end
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            PARITY: state_nxt = IDLE;
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        out = 1'b0;
        case (state)
            SYNC:    out = SYNC_PAD[bit_cnt];
            DATA:    out = shreg_msb;
`ifdef SYNC_FRAME_TX_PARITY_EN
            PARITY:  out = par_q;
`endif
            default: out = 1'b0;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);
    assign sof   = (state == SYNC) && (bit_cnt == SYNC_LAST);
`ifdef SYNC_FRAME_TX_PARITY_EN
    assign done  = (state == PARITY);
`else
    assign done  = (state == DATA) && (bit_cnt == '0);
`endif

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx (WIDTH=8, sync 1101): table frames, corner sequences, random traffic vs a bit-queue model.
module tb_sync_frame_tx;
    import sync_frame_pkg::*;

`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk, reset, valid, ready, out, busy, sof, done;
    logic [7:0] data_in;

    int n_cmp, n_bad;

    sync_frame_tx #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .out     (out),
        .busy    (busy),
        .sof     (sof),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [11:0] np;     // sync + data bits, first-sent bit leftmost
        logic        par;
        int          pulse;  // frame cycle index to pulse valid with 0x3C, -1 for none
    } vec_t;

    vec_t tbl[5];

    // Reference model: remaining bits of the frame in flight.
    logic mq[$];
    int   fpos;

    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {out, ready, busy, sof, done};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: out/ready/busy/sof/done got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic load_model(input logic [7:0] d);
        mq.delete();
        fpos = 0;
        for (int i = SYNC_LEN_DEF - 1; i >= 0; i--) mq.push_back(SYNC_PATTERN_DEF[i]);
        for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
        if (PAR) mq.push_back(^d);
    endtask

    // Called at a falling edge: check this cycle, drive inputs for the next rising edge, advance model.
    task automatic step(input logic v, input logic [7:0] d, input string name);
        logic [4:0] e;
        if (mq.size() != 0) e = {mq[0], 1'b0, 1'b1, fpos == 0, mq.size() == 1};
        else                e = 5'b01000;
        chk(name, e);
        valid   = v;
        data_in = d;
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            fpos++;
        end else if (v) begin
            load_model(d);
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input vec_t t, input string name);
        logic [12:0] f;
        int          len;
        if (PAR) begin
            f   = {t.np, t.par};
            len = 13;
        end else begin
            f   = {1'b0, t.np};
            len = 12;
        end
        valid   = 1'b1;
        data_in = t.d;
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            if (i == t.pulse) begin
                valid   = 1'b1;
                data_in = 8'h3C;
            end else begin
                valid   = 1'b0;
                data_in = ~t.d;
            end
            chk(name, {f[len-1-i], 1'b0, 1'b1, i == 0, i == len - 1});
            @(negedge clk);
        end
        valid = 1'b0;
        chk({name, "_end"}, 5'b01000);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        fpos    = 0;

        tbl[0] = '{8'hA5, 12'b1101_1010_0101, 1'b0, -1};
        tbl[1] = '{8'h07, 12'b1101_0000_0111, 1'b1, -1};
        tbl[2] = '{8'h00, 12'b1101_0000_0000, 1'b0, -1};
        tbl[3] = '{8'hFF, 12'b1101_1111_1111, 1'b0, -1};
        tbl[4] = '{8'hA5, 12'b1101_1010_0101, 1'b0, 2};

        @(negedge clk);
        chk("reset_idle", 5'b01000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

        // Valid held: 0x00 frame, one idle cycle, then 0xFF frame.
        step(1'b1, 8'h00, "b2b");
        for (int i = 0; i < 25; i++) step(1'b1, 8'hFF, "b2b");
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, "b2b_drain");

        // Reset in the middle of a frame, then a clean frame.
        step(1'b1, 8'hA5, "rst_pre");
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, "rst_pre");
        reset = 1'b1;
        #1;
        chk("reset_mid", 5'b01000);
        mq.delete();
        fpos = 0;
        @(negedge clk);
        chk("reset_hold", 5'b01000);
        reset = 1'b0;
        @(negedge clk);
        step(1'b1, 8'hFF, "post_rst");
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, "post_rst");

`ifndef SYNC_FRAME_TX_PARITY_EN
        // Encoding 2'b11 is unreachable without parity and must fall back to IDLE.
        force dut.state = PARITY;
        @(posedge clk);
        #1;
        release dut.state;
        @(posedge clk);
        #1;
        chk("illegal_state", 5'b01000);
        @(negedge clk);
`endif

        for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0, 8'($urandom), "rand");
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, "rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
